// File: rtl/ram_pkg.sv
// Shared types and constants for the RAM responder and its response FIFO.
// The response record carries a data field sized to DATA_W_DEF, so the top level only accepts DATA_W == DATA_W_DEF.
package ram_pkg;

    localparam int ADDR_W_DEF   = 16;
    localparam int DATA_W_DEF   = 32;
    localparam int DEPTH_DEF    = 512;
    localparam int READ_LAT_MIN = 1;
    localparam int READ_LAT_MAX = 4;

    typedef struct packed {
        logic                  we;
        logic [DATA_W_DEF-1:0] rdata;
        logic                  err;
    } rsp_t;

endpackage

// File: rtl/rsp_fifo.sv
// Synchronous response FIFO with a registered head entry.
// It accepts a push together with a pop when full, taking the pop first.
module rsp_fifo
    import ram_pkg::*;
#(
    parameter int RSP_DEPTH = 4
) (
    input  logic                           clka,
    input  logic                           rst,
    input  logic                           push,
    input  rsp_t                           push_data,
    input  logic                           pop,
    output rsp_t                           head,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(RSP_DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

    rsp_t          store [RSP_DEPTH];
    rsp_t          head_q;
    rsp_t          head_nxt;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && ((count_q != CW'(RSP_DEPTH)) || do_pop);

    always_ff @(posedge clka) begin
        if (do_push) begin
            store[wr_ptr] <= push_data;
        end
    end

    // The head follows the oldest entry; a push into an emptying FIFO bypasses storage.
    always_comb begin
        head_nxt = head_q;
        if (do_pop) begin
            if (count_q > CW'(1)) begin
                head_nxt = store[bump(rd_ptr)];
            end else begin
                head_nxt = do_push ? push_data : '0;
            end
        end else if (count_q == '0) begin
            head_nxt = do_push ? push_data : '0;
        end
    end

    always_ff @(posedge clka) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            head_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
            head_q  <= head_nxt;
        end
    end

    assign head  = head_q;
    assign full  = (count_q == CW'(RSP_DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/ram_responder.sv
// CPU-facing RAM responder: synchronous array, fixed-latency pipeline and in-order response FIFO.
// Define RAM_RESPONDER_BOUNDS_EN to fault addresses >= DEPTH instead of letting them alias.
module ram_responder
    import ram_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int READ_LAT  = 2,
    parameter int RSP_DEPTH = 4
) (
    input  logic              clka,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_we,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam int OW = $clog2(RSP_DEPTH + READ_LAT + 1);

    generate
        if (READ_LAT < READ_LAT_MIN || READ_LAT > READ_LAT_MAX || DATA_W != DATA_W_DEF) begin : g_param_check
            $error("ram_responder: READ_LAT must be 1..4 and DATA_W must equal DATA_W_DEF");
        end
    endgenerate

    logic [DATA_W-1:0]   ram [DEPTH];
    logic                rst_q;
    logic                accept;
    logic                pop;
    logic [AW-1:0]       idx;
    logic                addr_err;
    logic [READ_LAT-1:0] pipe_v;
    rsp_t                pipe_d [READ_LAT];
    rsp_t                fifo_head;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CW-1:0]       fifo_count;
    logic [OW-1:0]       outstanding;

    assign idx = AW'(req_addr);

`ifdef RAM_RESPONDER_BOUNDS_EN
    assign addr_err = ((ADDR_W + 1)'(req_addr) >= (ADDR_W + 1)'(DEPTH));
`else
    assign addr_err = 1'b0;
`endif

    assign accept = req_valid && req_ready && !rst;
    assign pop    = rsp_valid && rsp_ready;

    always_ff @(posedge clka) begin
        if (accept && req_we && !addr_err) begin
            ram[idx] <= req_wdata;
        end
    end

    // Data stages carry no reset; only the valid bits decide what reaches the FIFO.
    always_ff @(posedge clka) begin
        pipe_d[0].we    <= req_we;
        pipe_d[0].err   <= addr_err;
        pipe_d[0].rdata <= (req_we || addr_err) ? '0 : ram[idx];
        for (int i = 1; i < READ_LAT; i++) begin
            pipe_d[i] <= pipe_d[i-1];
        end
    end

    always_ff @(posedge clka) begin
        rst_q <= rst;
        if (rst) begin
            pipe_v <= '0;
        end else begin
            pipe_v <= READ_LAT'({pipe_v, accept});
        end
    end

    rsp_fifo #(
        .RSP_DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clka      (clka),
        .rst       (rst),
        .push      (pipe_v[READ_LAT-1]),
        .push_data (pipe_d[READ_LAT-1]),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Credits come from registered state only, so req_ready never depends on rsp_ready or req_valid.
    always_comb begin
        outstanding = OW'(fifo_count);
        for (int i = 0; i < READ_LAT; i++) begin
            outstanding = outstanding + OW'(pipe_v[i]);
        end
    end

    assign req_ready = !rst_q && !fifo_full && (outstanding < OW'(RSP_DEPTH));

    assign rsp_valid = !fifo_empty;
    assign rsp_we    = fifo_head.we;
    assign rsp_rdata = fifo_head.rdata;
    assign rsp_err   = fifo_head.err;

endmodule

// File: tb/tb_ram_responder.sv
// Scoreboard bench for ram_responder: directed scenarios plus randomized traffic against a word-level memory model.
// Honours RAM_RESPONDER_BOUNDS_EN in its model when the design is built with it.
module tb_ram_responder;

    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 32;
    localparam int DEPTH     = 512;
    localparam int READ_LAT  = 2;
    localparam int RSP_DEPTH = 4;

    logic              clka = 1'b0;
    logic              rst  = 1'b1;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_we;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    typedef struct {
        logic              we;
        logic [DATA_W-1:0] rdata;
        logic              err;
        int                acc;
        bit                chk;
    } exp_t;

    exp_t              exp_q [$];
    exp_t              mon_e;
    logic [DATA_W-1:0] model_mem [int];
    int                total = 0;
    int                bad   = 0;
    int                cyc   = 0;

    ram_responder #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .READ_LAT  (READ_LAT),
        .RSP_DEPTH (RSP_DEPTH)
    ) dut (
        .clka      (clka),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_we    (rsp_we),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clka = ~clka;

    always @(posedge clka) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %h, want %h", name, act, want);
        end
    endtask

    // Memory model: a word store indexed by address; out-of-range handling depends on the build.
    function automatic exp_t predict(input logic we, input int addr, input logic [DATA_W-1:0] wdata);
        exp_t e;
        int   word;
        bit   oob;
`ifdef RAM_RESPONDER_BOUNDS_EN
        oob  = (addr >= DEPTH);
        word = addr;
`else
        oob  = 1'b0;
        word = addr % DEPTH;
`endif
        e.we    = we;
        e.err   = oob;
        e.rdata = '0;
        e.acc   = 0;
        e.chk   = 1'b0;
        if (!oob) begin
            if (we) model_mem[word] = wdata;
            else    e.rdata = model_mem[word];
        end
        return e;
    endfunction

    // Drive one request until accepted; called and returning just after a rising edge.
    task automatic applyStimulus(input logic we, input int addr, input logic [DATA_W-1:0] wdata,
                                 input bit chk, input bit rnd);
        exp_t e;
        bit   accepted = 1'b0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = ADDR_W'(addr);
        req_wdata = wdata;
        for (int w = 0; w < 200 && !accepted; w++) begin
            @(negedge clka);
            if (req_ready === 1'b1) begin
                accepted = 1'b1;
                e        = predict(we, addr, wdata);
                e.acc    = cyc + 1;
                e.chk    = chk;
                exp_q.push_back(e);
            end
            @(posedge clka);
            #1;
            if (rnd) rsp_ready = ($urandom_range(0, 3) != 0);
        end
        req_valid = 1'b0;
        if (!accepted) checkOutput("req_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        for (int w = 0; w < 300 && exp_q.size() != 0; w++) begin
            @(posedge clka);
            #1;
        end
        checkOutput("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: every presented response is checked against the oldest expectation.
    always @(negedge clka) begin
        if (rst === 1'b0 && rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checkOutput("spurious_rsp_valid", 64'(rsp_valid), 64'd0);
            end else begin
                mon_e = exp_q[0];
                checkOutput(rsp_ready ? "rsp_pop" : "rsp_stall_head",
                            64'({rsp_we, rsp_err, rsp_rdata}),
                            64'({mon_e.we, mon_e.err, mon_e.rdata}));
                if (rsp_ready === 1'b1) begin
                    void'(exp_q.pop_front());
                    if (mon_e.chk) checkOutput("rsp_latency", 64'(cyc - mon_e.acc), 64'(READ_LAT));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b1;

        $display("[TB] reset");
        repeat (2) @(posedge clka);
        @(negedge clka);
        checkOutput("reset_outputs", 64'({req_ready, rsp_valid, rsp_we, rsp_err, rsp_rdata}), 64'd0);
        @(posedge clka);
        #1;
        rst = 1'b0;
        @(negedge clka);
        checkOutput("ready_still_low", 64'(req_ready), 64'd0);
        @(negedge clka);
        checkOutput("ready_after_release", 64'(req_ready), 64'd1);
        @(posedge clka);
        #1;

        $display("[TB] write then read");
        applyStimulus(1'b1, 'h10, 32'hDEADBEEF, 1'b1, 1'b0);
        applyStimulus(1'b0, 'h10, '0, 1'b1, 1'b0);
        drain();

        $display("[TB] streaming");
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, i, DATA_W'(i + 1), 1'b1, 1'b0);
        drain();
        for (int i = 0; i < 16; i++) applyStimulus(1'b0, i, '0, 1'b1, 1'b0);
        drain();

        $display("[TB] backpressure");
        rsp_ready = 1'b0;
        for (int i = 0; i < RSP_DEPTH; i++) applyStimulus(1'b0, i, '0, 1'b0, 1'b0);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = ADDR_W'(4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clka);
            checkOutput("bp_ready_low", 64'(req_ready), 64'd0);
            @(posedge clka);
            #1;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clka);
        checkOutput("bp_ready_before_pop", 64'(req_ready), 64'd0);
        @(negedge clka);
        checkOutput("bp_ready_after_pop", 64'(req_ready), 64'd1);
        @(posedge clka);
        #1;
        applyStimulus(1'b0, 4, '0, 1'b0, 1'b0);
        applyStimulus(1'b0, 5, '0, 1'b0, 1'b0);
        drain();

        $display("[TB] out of range");
        applyStimulus(1'b1, 'h0200, 32'hA5A50F0F, 1'b1, 1'b0);
        applyStimulus(1'b0, 'h0200, '0, 1'b1, 1'b0);
        applyStimulus(1'b0, 'h0000, '0, 1'b1, 1'b0);
        drain();

        $display("[TB] reset mid-flight");
        rsp_ready = 1'b0;
        for (int i = 1; i <= 3; i++) applyStimulus(1'b0, i, '0, 1'b0, 1'b0);
        rst = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clka);
        #1;
        rst       = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clka);
            checkOutput("flushed_no_rsp", 64'(rsp_valid), 64'd0);
        end
        @(posedge clka);
        #1;
        applyStimulus(1'b0, 'h10, '0, 1'b0, 1'b0);
        applyStimulus(1'b0, 5, '0, 1'b0, 1'b0);
        drain();

        $display("[TB] random traffic");
        for (int i = 16; i < 32; i++) applyStimulus(1'b1, i, $urandom, 1'b0, 1'b0);
        drain();
        for (int n = 0; n < 300; n++) begin
            int addr;
            addr = $urandom_range(0, 31);
            if ($urandom_range(0, 7) == 0) addr = addr + ($urandom_range(1, 127) << 9);
            applyStimulus(1'($urandom_range(0, 1)), addr, $urandom, 1'b0, 1'b1);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clka);
                #1;
            end
        end
        rsp_ready = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
